regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//   Parametrised register file: one synchronous write port and two independent
//   read ports (A, B), each with registered data and a 1-cycle valid strobe.
//   It generalises the 4x8 single-port register bank to arbitrary width and depth.
//   A hardware clear sequencer zeroes every entry on request.
//   It sits between the processor decode stage and the ALU operand muxes.
// PARAMETERS
//   WIDTH   8   data width of each entry, in bits
//   DEPTH   4   number of entries, >= 2; need not be a power of 2
//   ADDR_W  $clog2(DEPTH)   address width (derived; do not override)
// PORTS
//   clk         in   1       single clock; all logic on its rising edge
//   rst_n       in   1       reset, asynchronous and active-low
//   wr_en       in   1       write request, sampled at posedge
//   wr_addr     in   ADDR_W  write address
//   wr_data     in   WIDTH   write data
//   rd_en_a     in   1       port A read request
//   rd_addr_a   in   ADDR_W  port A read address
//   rd_data_a   out  WIDTH   port A read data (registered)
//   rd_valid_a  out  1       port A data valid, one-cycle pulse
//   rd_en_b     in   1       port B read request
//   rd_addr_b   in   ADDR_W  port B read address
//   rd_data_b   out  WIDTH   port B read data (registered)
//   rd_valid_b  out  1       port B data valid, one-cycle pulse
//   clr         in   1       start the clear sequence (pulse)
//   busy        out  1       clear sequence in progress
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous):
//   - All entries are 0; rd_data_a/b = 0; rd_valid_a/b = 0; busy = 0; FSM is IDLE.
// - Write:
//   - In IDLE with wr_en=1 and wr_addr<DEPTH, mem[wr_addr] <= wr_data at that posedge.
//   - A write with wr_addr>=DEPTH is dropped.
// - Read, ports A and B identical and independent:
//   - In IDLE with rd_en_x=1, the next cycle gives rd_data_x = mem[rd_addr_x] and rd_valid_x=1.
//   - Latency is 1 cycle. Back-to-back reads give one result per cycle.
//   - With rd_en_x=0, rd_valid_x goes to 0 and rd_data_x holds its last value.
//   - An out-of-range rd_addr_x returns 0 with rd_valid_x=1.
//   - Both ports may read the same address in the same cycle.
// - Same-cycle read and write to the same address: result is set by REGFILE_BYPASS_EN (below).
// - Clear FSM, states IDLE and CLEAR, with counter idx (ADDR_W bits):
//   - IDLE: clr=1 sets idx=0, moves to CLEAR, and drives busy=1 from the next cycle.
//   - CLEAR: each cycle mem[idx]<=0 and idx++. When idx==DEPTH-1 it returns to IDLE,
//     so busy is high for exactly DEPTH cycles.
//   - While busy: wr_en, rd_en_a/b and clr are all ignored; rd_valid stays 0.
//   - clr and wr_en in the same IDLE cycle: clr wins and the write is dropped.
//   - clr and rd_en in the same IDLE cycle: the read is accepted and returns pre-clear data.
//   - rst_n low mid-clear: immediate return to IDLE with busy=0; all entries are 0.
// CONFIGURATION
// - REGFILE_BYPASS_EN defined:
//   - A read of an address written in the same cycle returns the new wr_data (write-first).
//   - This applies per port, only when the write is accepted and in range.
// - REGFILE_BYPASS_EN undefined:
//   - The same read returns the old contents (read-first).
//   - The new value is visible to reads issued from the next cycle on.
// TESTING (WIDTH=8, DEPTH=4 unless stated)
// 1. Write 00,02,01,11 (hex) to addresses 0..3, then read A at 0..3 on consecutive cycles
//    -> rd_data_a = 00,02,01,11 on cycles +1..+4, each with rd_valid_a=1.
// 2. Same cycle: A reads addr 1, B reads addr 3
//    -> next cycle rd_data_a=02 and rd_data_b=11, both valid.
// 3. Address 2 holds 01; write 5A to addr 2 and read A addr 2 in the same cycle
//    -> with the macro defined rd_data_a=5A; without it rd_data_a=01, and a read next cycle gives 5A.
// 4. Pulse clr with wr_en to addr 0 (data FF) in the same cycle
//    -> busy=1 for 4 cycles; reads are ignored while busy; afterwards all entries read 00, never FF.
// 5. Drop rst_n during cycle 2 of a clear
//    -> busy=0, rd_valid=0 and outputs 0 immediately; after release all entries read 00.
// 6. DEPTH=5: write to addr 7 and read addr 6
//    -> no entry changes; rd_data=00 with rd_valid=1.

Source files
------------

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file with a hardware clear sequencer.
// Define REGFILE_BYPASS_EN for write-first reads; the default build is read-first.
module regfile_2r1w #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en_a,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    output logic [WIDTH-1:0]  o_rd_data_a,
    output logic              o_rd_valid_a,
    input  logic              i_rd_en_b,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    output logic [WIDTH-1:0]  o_rd_data_b,
    output logic              o_rd_valid_b,
    input  logic              i_clr,
    output logic              o_busy
);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic [WIDTH-1:0]  r_data_a;
    logic [WIDTH-1:0]  r_data_b;
    logic              r_valid_a;
    logic              r_valid_b;

    logic              w_idle;
    logic              w_wr_ok;
    logic              w_wr_in;
    logic              w_rd_ok_a;
    logic              w_rd_ok_b;
    logic              w_byp_a;
    logic              w_byp_b;
    logic [WIDTH-1:0]  w_mem_a;
    logic [WIDTH-1:0]  w_mem_b;
    logic [WIDTH-1:0]  w_rdata_a;
    logic [WIDTH-1:0]  w_rdata_b;

    assign w_idle    = (r_state == S_IDLE);
    // clr takes priority over a same-cycle write
    assign w_wr_ok   = w_idle && i_wr_en && !i_clr;
    assign w_wr_in   = {1'b0, i_wr_addr} < (ADDR_W+1)'(DEPTH);
    assign w_rd_ok_a = w_idle && i_rd_en_a;
    assign w_rd_ok_b = w_idle && i_rd_en_b;

`ifdef REGFILE_BYPASS_EN
    assign w_byp_a = w_wr_ok && w_wr_in && (i_wr_addr == i_rd_addr_a);
    assign w_byp_b = w_wr_ok && w_wr_in && (i_wr_addr == i_rd_addr_b);
`else
    assign w_byp_a = 1'b0;
    assign w_byp_b = 1'b0;
`endif

    // Out-of-range addresses match no entry and read back as zero
    always_comb begin
        w_mem_a = '0;
        w_mem_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_rd_addr_a == ADDR_W'(i)) w_mem_a = r_mem[i];
            if (i_rd_addr_b == ADDR_W'(i)) w_mem_b = r_mem[i];
        end
    end

    assign w_rdata_a = w_byp_a ? i_wr_data : w_mem_a;
    assign w_rdata_b = w_byp_b ? i_wr_data : w_mem_b;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            S_IDLE: begin
                if (i_clr) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_idx_nxt = r_idx + ADDR_W'(1);
                if (r_idx == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!w_idle && r_idx == ADDR_W'(i))
                    r_mem[i] <= '0;
                else if (w_wr_ok && i_wr_addr == ADDR_W'(i))
                    r_mem[i] <= i_wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_a  <= '0;
            r_data_b  <= '0;
            r_valid_a <= 1'b0;
            r_valid_b <= 1'b0;
        end else begin
            r_valid_a <= w_rd_ok_a;
            r_valid_b <= w_rd_ok_b;
            if (w_rd_ok_a) r_data_a <= w_rdata_a;
            if (w_rd_ok_b) r_data_b <= w_rdata_b;
        end
    end

    assign o_rd_data_a  = r_data_a;
    assign o_rd_valid_a = r_valid_a;
    assign o_rd_data_b  = r_data_b;
    assign o_rd_valid_b = r_valid_b;
    assign o_busy       = !w_idle;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: randomized bench for regfile_2r1w against an array model.
// Covers read/write, dual read, same-cycle bypass, clear, reset and range limits.
module tb_regfile_2r1w;

    localparam int D = 4;
    localparam bit BYP =
`ifdef REGFILE_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en_a = 1'b0;
    logic [1:0] rd_addr_a = '0;
    logic       rd_en_b = 1'b0;
    logic [1:0] rd_addr_b = '0;
    logic       clr = 1'b0;
    logic [7:0] da, db;
    logic       va, vb, busy;

    logic       wr_en5 = 1'b0;
    logic [2:0] wr_addr5 = '0;
    logic [7:0] wr_data5 = '0;
    logic       rd_en_a5 = 1'b0;
    logic [2:0] rd_addr_a5 = '0;
    logic       rd_en_b5 = 1'b0;
    logic [2:0] rd_addr_b5 = '0;
    logic       clr5 = 1'b0;
    logic [7:0] da5, db5;
    logic       va5, vb5, busy5;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] m_mem [D];
    int         m_clr_left;
    logic [7:0] e_da, e_db;
    logic       e_va, e_vb;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_en_a(rd_en_a), .i_rd_addr_a(rd_addr_a),
        .o_rd_data_a(da), .o_rd_valid_a(va),
        .i_rd_en_b(rd_en_b), .i_rd_addr_b(rd_addr_b),
        .o_rd_data_b(db), .o_rd_valid_b(vb),
        .i_clr(clr), .o_busy(busy)
    );

    regfile_2r1w #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .i_wr_en(wr_en5), .i_wr_addr(wr_addr5), .i_wr_data(wr_data5),
        .i_rd_en_a(rd_en_a5), .i_rd_addr_a(rd_addr_a5),
        .o_rd_data_a(da5), .o_rd_valid_a(va5),
        .i_rd_en_b(rd_en_b5), .i_rd_addr_b(rd_addr_b5),
        .o_rd_data_b(db5), .o_rd_valid_b(vb5),
        .i_clr(clr5), .o_busy(busy5)
    );

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = 8'h00;
        m_clr_left = 0;
        e_da = 8'h00;
        e_db = 8'h00;
        e_va = 1'b0;
        e_vb = 1'b0;
    endtask

    function automatic logic [7:0] model_read(int a, bit wok);
        if (a >= D) return 8'h00;
        if (BYP && wok && a == int'(wr_addr)) return wr_data;
        return m_mem[a];
    endfunction

    // Apply the current inputs to the model, then advance one clock
    task automatic tick();
        bit wok;
        if (m_clr_left > 0) begin
            m_mem[D - m_clr_left] = 8'h00;
            m_clr_left--;
            e_va = 1'b0;
            e_vb = 1'b0;
        end else begin
            wok = wr_en && !clr && (int'(wr_addr) < D);
            e_va = rd_en_a;
            e_vb = rd_en_b;
            if (rd_en_a) e_da = model_read(int'(rd_addr_a), wok);
            if (rd_en_b) e_db = model_read(int'(rd_addr_b), wok);
            if (wok) m_mem[wr_addr] = wr_data;
            if (clr) m_clr_left = D;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit we, int wa, int wd, bit ea, int aa,
                         bit eb, int ab, bit c);
        wr_en = we;
        wr_addr = 2'(wa);
        wr_data = 8'(wd);
        rd_en_a = ea;
        rd_addr_a = 2'(aa);
        rd_en_b = eb;
        rd_addr_b = 2'(ab);
        clr = c;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({busy, va, vb, da, db} !== 19'h0) begin
            n_err++;
            $display("FAIL reset_out got %h exp 0", {busy, va, vb, da, db});
        end
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) begin
            drive(0, 0, 0, 1, i, 1, D - 1 - i, 0);
            n_chk++;
            if ({va, vb, da, db} !== {2'b11, 16'h0}) begin
                n_err++;
                $display("FAIL reset_mem a=%0d got %h exp 30000", i, {va, vb, da, db});
            end
        end
    endtask

    task automatic test_write_read();
        logic [7:0] vals [D];
        vals = '{8'h00, 8'h02, 8'h01, 8'h11};
        for (int i = 0; i < D; i++) drive(1, i, vals[i], 0, 0, 0, 0, 0);
        for (int i = 0; i < D; i++) begin
            drive(0, 0, 0, 1, i, 0, 0, 0);
            n_chk++;
            if ({va, da} !== {1'b1, vals[i]} || {va, da} !== {e_va, e_da}) begin
                n_err++;
                $display("FAIL write_read a=%0d got %h exp %h", i, {va, da}, {1'b1, vals[i]});
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        n_chk++;
        if ({va, da} !== {1'b0, vals[D-1]}) begin
            n_err++;
            $display("FAIL read_hold got %h exp %h", {va, da}, {1'b0, vals[D-1]});
        end
    endtask

    task automatic test_dual_read();
        drive(0, 0, 0, 1, 1, 1, 3, 0);
        n_chk++;
        if ({va, vb, da, db} !== {2'b11, 8'h02, 8'h11}) begin
            n_err++;
            $display("FAIL dual_read got %h exp 30211", {va, vb, da, db});
        end
        for (int k = 0; k < 40; k++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 3), 0);
            n_chk++;
            if ({busy, va, vb, da, db} !== {m_clr_left > 0, e_va, e_vb, e_da, e_db}) begin
                n_err++;
                $display("FAIL dual_rand k=%0d got %h exp %h", k, {busy, va, vb, da, db},
                         {m_clr_left > 0, e_va, e_vb, e_da, e_db});
            end
        end
    endtask

    task automatic test_same_cycle_rw();
        logic [7:0] exp_v;
        drive(1, 2, 8'h01, 0, 0, 0, 0, 0);
        drive(1, 2, 8'h5A, 1, 2, 1, 2, 0);
        exp_v = BYP ? 8'h5A : 8'h01;
        n_chk++;
        if ({va, vb, da, db} !== {2'b11, exp_v, exp_v}) begin
            n_err++;
            $display("FAIL same_rw got %h exp %h", {va, vb, da, db}, {2'b11, exp_v, exp_v});
        end
        drive(0, 0, 0, 1, 2, 0, 0, 0);
        n_chk++;
        if ({va, da} !== {1'b1, 8'h5A}) begin
            n_err++;
            $display("FAIL same_rw_next got %h exp 15a", {va, da});
        end
    endtask

    task automatic test_clear();
        logic [7:0] pre;
        for (int i = 0; i < D; i++) drive(1, i, $urandom_range(1, 254), 0, 0, 0, 0, 0);
        pre = m_mem[1];
        drive(1, 0, 8'hFF, 1, 1, 0, 0, 1);
        n_chk++;
        if ({busy, va, da} !== {2'b11, pre}) begin
            n_err++;
            $display("FAIL clr_start got %h exp %h", {busy, va, da}, {2'b11, pre});
        end
        for (int k = 1; k <= D; k++) begin
            drive(1, $urandom_range(0, 3), 8'hFF, 1, $urandom_range(0, 3),
                  1, $urandom_range(0, 3), $urandom_range(0, 1));
            n_chk++;
            if ({busy, va, vb} !== {k < D, 2'b00} || busy !== (m_clr_left > 0)) begin
                n_err++;
                $display("FAIL clr_busy k=%0d got %b exp %b", k, {busy, va, vb}, {k < D, 2'b00});
            end
        end
        for (int i = 0; i < D; i++) begin
            drive(0, 0, 0, 1, i, 1, i, 0);
            n_chk++;
            if ({va, vb, da, db} !== {2'b11, 16'h0}) begin
                n_err++;
                $display("FAIL clr_mem a=%0d got %h exp 30000", i, {va, vb, da, db});
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < D; i++) drive(1, i, $urandom_range(1, 255), 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        n_chk++;
        if ({busy, va, vb, da, db} !== 19'h0) begin
            n_err++;
            $display("FAIL rst_mid got %h exp 0", {busy, va, vb, da, db});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) begin
            drive(0, 0, 0, 1, i, 1, i, 0);
            n_chk++;
            if ({busy, va, vb, da, db} !== {3'b011, 16'h0}) begin
                n_err++;
                $display("FAIL rst_mid_mem a=%0d got %h exp 30000", i, {busy, va, vb, da, db});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 19) == 0);
            n_chk++;
            if ({busy, va, vb, da, db} !== {m_clr_left > 0, e_va, e_vb, e_da, e_db}) begin
                n_err++;
                $display("FAIL random k=%0d got %h exp %h", k, {busy, va, vb, da, db},
                         {m_clr_left > 0, e_va, e_vb, e_da, e_db});
            end
        end
    endtask

    task automatic test_out_of_range();
        wr_en5 = 1'b1;
        wr_addr5 = 3'd7;
        wr_data5 = 8'hAA;
        rd_en_a5 = 1'b1;
        rd_addr_a5 = 3'd6;
        rd_en_b5 = 1'b1;
        rd_addr_b5 = 3'd7;
        @(posedge clk);
        #1;
        wr_en5 = 1'b0;
        n_chk++;
        if ({va5, vb5, da5, db5} !== {2'b11, 16'h0}) begin
            n_err++;
            $display("FAIL oob_read got %h exp 30000", {va5, vb5, da5, db5});
        end
        for (int i = 0; i < 5; i++) begin
            rd_addr_a5 = 3'(i);
            rd_addr_b5 = 3'(4 - i);
            @(posedge clk);
            #1;
            n_chk++;
            if ({va5, vb5, da5, db5} !== {2'b11, 16'h0}) begin
                n_err++;
                $display("FAIL oob_mem a=%0d got %h exp 30000", i, {va5, vb5, da5, db5});
            end
        end
        wr_en5 = 1'b1;
        wr_addr5 = 3'd4;
        wr_data5 = 8'h33;
        rd_en_a5 = 1'b0;
        rd_en_b5 = 1'b0;
        @(posedge clk);
        #1;
        wr_en5 = 1'b0;
        rd_en_a5 = 1'b1;
        rd_addr_a5 = 3'd4;
        rd_en_b5 = 1'b1;
        rd_addr_b5 = 3'd5;
        @(posedge clk);
        #1;
        rd_en_a5 = 1'b0;
        rd_en_b5 = 1'b0;
        n_chk++;
        if ({busy5, va5, vb5, da5, db5} !== {3'b011, 8'h33, 8'h00}) begin
            n_err++;
            $display("FAIL last_entry got %h exp 33300", {busy5, va5, vb5, da5, db5});
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_dual_read();
        test_same_cycle_rw();
        test_clear();
        test_reset_mid_clear();
        test_random();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
